// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one byte-wide, synchronous-read RAM between a 64-bit instruction
//   fetch port (I, read-only) and a 64-bit data port (D, read/write).
//   Requests are arbitrated round-robin. Each 64-bit access is split into
//   8 little-endian byte cycles. Every request is bounds-checked.
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   i_req/i_addr    : fetch request (held until i_ack) and byte address
//   i_ack/i_rdata/i_err : one-cycle completion, read data (held), error flag
//   d_req/d_we/d_addr/d_wdata : data request, store select, address, store data
//   d_ack/d_rdata/d_err : one-cycle completion, load data (held), error flag
//   ram_en/ram_we/ram_addr/ram_wdata : byte RAM command
//   ram_rdata       : byte RAM read data, valid one cycle after a read
module mem_port_arbiter #(
  parameter int MEM_SIZE = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [63:0]       i_addr,
  output logic              i_ack,
  output logic [63:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [63:0]       d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_ack,
  output logic [63:0]       d_rdata,
  output logic              d_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

  // Highest legal base address; comparing against it avoids computing addr+7.
  localparam logic [63:0] LAST_ADDR = 64'(MEM_SIZE - 8);

  state_t             state_reg, state_next;
  logic               owner_reg;        // 1 = D port, 0 = I port
  logic               last_grant_reg;   // 1 = D port, 0 = I port
  logic [ADDR_W-1:0]  base_reg;
  logic               we_reg;
  logic [63:0]        wdata_reg;
  logic               err_reg;
  logic [2:0]         k_reg;
  logic [63:0]        rbuf_reg;
  logic [63:0]        i_rdata_reg;
  logic [63:0]        d_rdata_reg;

  logic               grant;
  logic               grant_d;
  logic [63:0]        req_addr;
  logic               addr_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    grant_d    = 1'b0;
    req_addr   = i_addr;
    addr_bad   = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = base_reg + ADDR_W'(k_reg);
    ram_wdata  = wdata_reg[{k_reg, 3'b000} +: 8];
    i_ack      = 1'b0;
    d_ack      = 1'b0;
    i_err      = 1'b0;
    d_err      = 1'b0;

    case (state_reg)
      IDLE: begin
        grant = i_req | d_req;
        // On a tie the port that did not win last time is served.
        grant_d  = d_req & (~i_req | ~last_grant_reg);
        req_addr = grant_d ? d_addr : i_addr;
        addr_bad = req_addr > LAST_ADDR;
        if (grant) begin
          state_next = addr_bad ? DONE : XFER;
        end
      end
      XFER: begin
        ram_en = 1'b1;
        ram_we = we_reg;
        if (k_reg == 3'd7) begin
          state_next = we_reg ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        state_next = DONE;
      end
      DONE: begin
        i_ack      = ~owner_reg;
        d_ack      = owner_reg;
        i_err      = ~owner_reg & err_reg;
        d_err      = owner_reg & err_reg;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b0;
      base_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      err_reg        <= 1'b0;
      k_reg          <= '0;
      rbuf_reg       <= '0;
      i_rdata_reg    <= '0;
      d_rdata_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant) begin
            owner_reg      <= grant_d;
            last_grant_reg <= grant_d;
            base_reg       <= req_addr[ADDR_W-1:0];
            we_reg         <= grant_d & d_we;
            wdata_reg      <= d_wdata;
            err_reg        <= addr_bad;
            k_reg          <= '0;
          end
        end
        XFER: begin
          k_reg <= k_reg + 3'd1;
          // The byte arriving now was issued in the previous XFER cycle.
          if (!we_reg && k_reg != 3'd0) begin
            rbuf_reg[{k_reg - 3'd1, 3'b000} +: 8] <= ram_rdata;
          end
        end
        DRAIN: begin
          // Byte 7 goes straight into the owner's result register so the
          // full word is already valid in the ack cycle that follows.
          if (owner_reg) begin
            d_rdata_reg <= {ram_rdata, rbuf_reg[55:0]};
          end else begin
            i_rdata_reg <= {ram_rdata, rbuf_reg[55:0]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign i_rdata = i_rdata_reg;
  assign d_rdata = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int MEM_SIZE = 1024;
  localparam int ADDR_W   = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_req = 1'b0;
  logic [63:0]       i_addr = '0;
  logic              i_ack;
  logic [63:0]       i_rdata;
  logic              i_err;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [63:0]       d_addr = '0;
  logic [63:0]       d_wdata = '0;
  logic              d_ack;
  logic [63:0]       d_rdata;
  logic              d_err;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  mem_port_arbiter #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Byte RAM model with registered read.
  logic [7:0] mem [0:MEM_SIZE-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  // RAM activity monitor: running counts plus first/last address of a burst.
  int                en_cnt = 0;
  int                we_cnt = 0;
  logic              en_prev = 1'b0;
  logic [ADDR_W-1:0] first_addr = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  always @(posedge clk) begin
    en_prev <= ram_en;
    if (ram_en) begin
      en_cnt    <= en_cnt + 1;
      last_addr <= ram_addr;
      if (!en_prev) first_addr <= ram_addr;
      if (ram_we) we_cnt <= we_cnt + 1;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        port;    // 1 = D, 0 = I
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          lat;
    logic        err;
    int          en_n;
    int          we_n;
    logic [63:0] exp_i;
    logic [63:0] exp_d;
  } vec_t;

  // Issues one request in an IDLE cycle, waits for its ack, checks it, and
  // returns once the DUT is back in IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    int   en0, we0, n;
    logic other_ack, got;
    en0 = en_cnt;
    we0 = we_cnt;
    other_ack = 1'b0;
    got = 1'b0;
    if (v.port) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    n = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (v.port ? i_ack : d_ack) other_ack = 1'b1;
      got = v.port ? d_ack : i_ack;
    end
    check($sformatf("v%0d latency", idx), 64'(n), 64'(v.lat));
    check($sformatf("v%0d err", idx), 64'(v.port ? d_err : i_err), 64'(v.err));
    check($sformatf("v%0d i_rdata", idx), i_rdata, v.exp_i);
    check($sformatf("v%0d d_rdata", idx), d_rdata, v.exp_d);
    check($sformatf("v%0d other_ack", idx), 64'(other_ack), 64'(0));
    i_req = 1'b0;
    d_req = 1'b0;
    @(posedge clk); #1;
    check($sformatf("v%0d ram_en_cycles", idx), 64'(en_cnt - en0), 64'(v.en_n));
    check($sformatf("v%0d ram_we_cycles", idx), 64'(we_cnt - we0), 64'(v.we_n));
    if (v.en_n != 0) begin
      check($sformatf("v%0d first_addr", idx), 64'(first_addr), 64'(v.addr[ADDR_W-1:0]));
      check($sformatf("v%0d last_addr", idx), 64'(last_addr), 64'(v.addr[ADDR_W-1:0] + 10'd7));
    end
    $display("vec %0d port=%s we=%0d addr=%h lat=%0d err=%0d i_rdata=%h d_rdata=%h",
             idx, v.port ? "D" : "I", v.we, v.addr, n, v.port ? d_err : i_err, i_rdata, d_rdata);
  endtask

  task automatic do_reset();
    i_req = 1'b0;
    d_req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  localparam logic [63:0] W0 = 64'h1122334455667788;
  localparam logic [63:0] W1 = 64'h0102030405060708;
  localparam logic [63:0] W2 = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] OLD32 = 64'h8877665544332211;
  localparam logic [63:0] NEW32 = 64'hF0E0D0C0B0A09080;

  vec_t vecs [12];

  initial begin
    vec_t v;
    int   n, d_cyc, i_cyc;
    logic overlap, seen, any_ack;
    logic [63:0] b;

    //            port  we    addr                   wdata lat err en we exp_i exp_d
    vecs[0]  = '{1'b1, 1'b1, 64'd16,                 W0,  9,  1'b0, 8, 8, 64'd0, 64'd0};
    vecs[1]  = '{1'b1, 1'b0, 64'd16,                 '0,  10, 1'b0, 8, 0, 64'd0, W0};
    vecs[2]  = '{1'b1, 1'b1, 64'd1016,               W1,  9,  1'b0, 8, 8, 64'd0, W0};
    vecs[3]  = '{1'b1, 1'b0, 64'd1016,               '0,  10, 1'b0, 8, 0, 64'd0, W1};
    vecs[4]  = '{1'b1, 1'b0, 64'd1017,               '0,  1,  1'b1, 0, 0, 64'd0, W1};
    vecs[5]  = '{1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF,   '0,  1,  1'b1, 0, 0, 64'd0, W1};
    vecs[6]  = '{1'b1, 1'b1, 64'd1017,               W2,  1,  1'b1, 0, 0, 64'd0, W1};
    vecs[7]  = '{1'b0, 1'b0, 64'd16,                 '0,  10, 1'b0, 8, 0, W0,    W1};
    vecs[8]  = '{1'b0, 1'b0, 64'd1017,               '0,  1,  1'b1, 0, 0, W0,    W1};
    vecs[9]  = '{1'b1, 1'b1, 64'd0,                  W2,  9,  1'b0, 8, 8, W0,    W1};
    vecs[10] = '{1'b0, 1'b0, 64'd0,                  '0,  10, 1'b0, 8, 0, W2,    W1};
    vecs[11] = '{1'b1, 1'b0, 64'd0,                  '0,  10, 1'b0, 8, 0, W2,    W2};

    // Reset state
    #1;
    check("reset ram outputs", 64'({ram_en, ram_we, ram_addr, ram_wdata}), 64'd0);
    check("reset acks/errs", 64'({i_ack, d_ack, i_err, d_err}), 64'd0);
    check("reset i_rdata", i_rdata, 64'd0);
    check("reset d_rdata", d_rdata, 64'd0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      run_vec(i, vecs[i]);
      if (i == 0) begin
        b = {mem[23], mem[22], mem[21], mem[20], mem[19], mem[18], mem[17], mem[16]};
        check("store byte order", b, W0);
      end
    end

    // I request raised during DRAIN of a D load; D's req dropped early.
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd16;
    i_addr = 64'd1016;
    d_cyc = 0; i_cyc = 0; overlap = 1'b0; n = 0;
    while (i_cyc == 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (n == 3) d_req = 1'b0;
      if (n == 9) i_req = 1'b1;
      if (i_ack && d_ack) overlap = 1'b1;
      if (d_ack) begin
        d_cyc = n;
        check("drain d_rdata at d_ack", d_rdata, W0);
        check("drain i_rdata held", i_rdata, W2);
      end
      if (i_ack) begin
        i_cyc = n;
        i_req = 1'b0;
        check("drain i_rdata at i_ack", i_rdata, W1);
        check("drain d_rdata unaffected", d_rdata, W0);
      end
    end
    check("drain d_ack cycle", 64'(d_cyc), 64'd10);
    check("drain i_ack cycle", 64'(i_cyc), 64'd21);
    check("drain ack overlap", 64'(overlap), 64'd0);
    $display("drain seq d_ack@%0d i_ack@%0d", d_cyc, i_cyc);
    @(posedge clk); #1;

    // Reset in the middle of a store, at byte k=3.
    v = '{1'b1, 1'b1, 64'd32, OLD32, 9, 1'b0, 8, 8, W1, W0};
    run_vec(12, v);
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'd32; d_wdata = NEW32;
    repeat (4) @(posedge clk);
    #1;
    check("midstore ram_addr k3", 64'({ram_en, ram_we, ram_addr}), 64'({1'b1, 1'b1, 10'd35}));
    rst_n = 1'b0;
    #1;
    check("async reset ram outputs", 64'({ram_en, ram_we, ram_addr, ram_wdata}), 64'd0);
    check("async reset acks/errs", 64'({i_ack, d_ack, i_err, d_err}), 64'd0);
    check("async reset rdata", i_rdata | d_rdata, 64'd0);
    d_req = 1'b0;
    any_ack = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (i_ack || d_ack) any_ack = 1'b1;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (i_ack || d_ack) any_ack = 1'b1;
    check("no ack after abort", 64'(any_ack), 64'd0);
    $display("midstore reset: ack_seen=%0d", any_ack);
    v = '{1'b1, 1'b0, 64'd32, '0, 10, 1'b0, 8, 0, 64'd0, 64'h8877665544A09080};
    run_vec(13, v);

    // Continuous tie: grants alternate D, I, D, I starting after reset.
    do_reset();
    i_req = 1'b1; i_addr = 64'd16;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd0;
    for (int t = 0; t < 4; t++) begin
      seen = 1'b0; overlap = 1'b0; n = 0;
      while (!seen && n < 40) begin
        @(posedge clk); #1;
        n++;
        if (i_ack && d_ack) overlap = 1'b1;
        seen = i_ack | d_ack;
      end
      check($sformatf("tie%0d winner_is_d", t), 64'(d_ack), 64'(t % 2 == 0));
      check($sformatf("tie%0d overlap", t), 64'(overlap), 64'd0);
      check($sformatf("tie%0d data", t), d_ack ? d_rdata : i_rdata, d_ack ? W2 : W0);
      $display("tie %0d: winner=%s after %0d cycles", t, d_ack ? "D" : "I", n);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one byte-wide, synchronous-read data RAM between two 64-bit requesters: the instruction-fetch port (read-only, I) and the data-memory port (read/write, D).
- Arbitrates between them round-robin.
- Sequences each 64-bit access as 8 little-endian byte cycles and bounds-checks every request.
- Sits between the fetch/memory stages and the RAM macro, and replaces direct combinational memory access.

Parameters:
MEM_SIZE, 1024, RAM size in bytes.
ADDR_W, 10, RAM address width; must equal clog2(MEM_SIZE).

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
i_req  input  1  fetch request; held high until i_ack
i_addr  input  64  fetch byte address
i_ack  output  1  one-cycle completion pulse to fetch port
i_rdata  output  64  fetch read data; valid with i_ack, held until next I completion
i_err  output  1  address error; valid only while i_ack=1
d_req  input  1  data request; held high until d_ack
d_we  input  1  1=store, 0=load
d_addr  input  64  data byte address
d_wdata  input  64  store data
d_ack  output  1  one-cycle completion pulse to data port
d_rdata  output  64  load data; valid with d_ack, held until next D load completion
d_err  output  1  address error; valid only while d_ack=1
ram_en  output  1  RAM access enable
ram_we  output  1  RAM byte write enable
ram_addr  output  ADDR_W  RAM byte address
ram_wdata  output  8  RAM write byte
ram_rdata  input  8  RAM read byte; valid one cycle after ram_en=1, ram_we=0

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs go to 0; state goes to IDLE; byte counter goes to 0; last_grant goes to I.
  - Reset mid-transfer aborts it with no ack.
  - Bytes already written during an aborted store remain in RAM.
- States: IDLE, XFER, DRAIN, DONE.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port that is not last_grant. After reset, D therefore wins the first tie.
  - On grant, latch owner, addr, we, and wdata (we is forced 0 for I), and set last_grant=owner.
  - Bounds check uses a 64-bit compare: addr > MEM_SIZE-8 is an error. The last legal address is MEM_SIZE-8, which avoids addr+7 overflow.
  - Error grant goes IDLE->DONE with err=1 and no RAM activity.
  - Legal grant goes IDLE->XFER with counter k=0.
- XFER (k=0..7):
  - Drive ram_en=1, ram_addr=base+k (low ADDR_W bits), and ram_we=we.
  - For stores, ram_wdata=wdata[8k+7:8k].
  - For loads, capture the byte returned in cycle k+1 into rdata[8(k)+7:8k]; this is byte k-1 relative to the current issue.
  - k=7 store -> DONE; k=7 load -> DRAIN.
- DRAIN (loads only):
  - ram_en=0.
  - Capture byte 7 into rdata[63:56].
  - Go to DONE.
- DONE:
  - Pulse owner ack=1 for exactly one cycle, with err as latched.
  - Update owner rdata register on loads only. Stores and errors leave rdata unchanged.
  - Go to IDLE.
- RAM outputs outside XFER: ram_en=0, ram_we=0. ram_addr and ram_wdata may hold last values.
- Latency, counting the cycle req is first seen in IDLE as 0:
  - Error: ack in cycle 1.
  - Store: ack in cycle 9.
  - Load: ack in cycle 10.
  - Back-to-back: next grant is evaluated in the IDLE cycle following DONE.
- Handshake:
  - A requester must deassert req (or present a new request) by the edge ending its ack cycle.
  - req held high in IDLE after ack is treated as a new request.
  - req, addr, and data changes after grant are ignored until ack.
  - req dropped before ack does not cancel; the access completes and ack still pulses.
- The non-granted requester waits; it is guaranteed service at the next tie because of round-robin.
- Store bytes land at little-endian positions: byte k of data goes to address base+k.

Test Plan:
- Reset, then D store addr=16 data=0x1122334455667788 -> ram_we pulses 8 cycles with addr 16..23 and bytes 88,77,66,55,44,33,22,11; d_ack in cycle 9, d_err=0.
- D load addr=16 after the above -> d_ack in cycle 10, d_rdata=0x1122334455667788; i_ack stays 0.
- i_req and d_req asserted together continuously for 4 transactions -> grants D,I,D,I; acks never overlap.
- D load addr=MEM_SIZE-8 (1016) -> legal, 8 RAM reads. addr=1017 and addr=0xFFFFFFFFFFFFFFFF -> d_ack in cycle 1 with d_err=1, ram_en never asserted, d_rdata unchanged.
- I fetch during DRAIN of D load -> I granted in IDLE after D's ack; i_rdata correct, d_rdata unaffected.
- rst_n low at XFER k=3 of a store -> all outputs 0 immediately, no ack. After release, a load of the same address returns new bytes 0..2 and old bytes 3..7.
